escalonador_ativos: RTL and testbench

ESCALONADOR_ATIVOS -- requirements
Module: escalonador_ativos

---
 rtl/escalonador_ativos.sv | 237 +++++++++++++++++++++++
 tb/tb_escalonador_ativos.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/escalonador_ativos.sv
// Scheduler for a pool of active nodes: inserts/updates node entries in slots
// and extracts the node with the minimum criterion via a sequential scan.
module escalonador_ativos #(
    parameter int N_NOS           = 8,
    parameter int ADR_WIDTH       = 5,
    parameter int DISTANCIA_WIDTH = 5,
    parameter int CRITERIO_WIDTH  = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ins_valid_in,
    input  logic [ADR_WIDTH-1:0]          ins_endereco_in,
    input  logic [DISTANCIA_WIDTH-1:0]    ins_distancia_in,
    input  logic [ADR_WIDTH-1:0]          ins_anterior_in,
    input  logic                          prox_valid_in,
    output logic                          ready_out,
    input  logic [N_NOS-1:0]              na_ativo_in,
    input  logic [N_NOS*ADR_WIDTH-1:0]    na_endereco_in,
    input  logic [N_NOS*CRITERIO_WIDTH-1:0] na_criterio_in,
    output logic                          ga_habilitar_out,
    output logic [N_NOS-1:0]              atualizar_out,
    output logic [N_NOS-1:0]              desativar_out,
    output logic [ADR_WIDTH-1:0]          endereco_out,
    output logic [DISTANCIA_WIDTH-1:0]    distancia_out,
    output logic [ADR_WIDTH-1:0]          anterior_out,
    output logic                          resp_valid_out,
    output logic [ADR_WIDTH-1:0]          resp_endereco_out,
    output logic [CRITERIO_WIDTH-1:0]     resp_criterio_out,
    output logic                          resp_vazio_out,
    output logic                          erro_cheio_out
);

    localparam int IDX_W = (N_NOS > 1) ? $clog2(N_NOS) : 1;
    localparam logic [IDX_W-1:0] ULTIMO = IDX_W'(N_NOS - 1);

    typedef enum logic [2:0] {
        IDLE, BUSCA, ESCRITA, SELECAO, REMOCAO, ESPERA
    } estado_t;

    estado_t                   estado_q, estado_d;
    logic [ADR_WIDTH-1:0]      ins_adr_q, ins_adr_d;
    logic [DISTANCIA_WIDTH-1:0] ins_dist_q, ins_dist_d;
    logic [ADR_WIDTH-1:0]      ins_ant_q, ins_ant_d;
    logic [IDX_W-1:0]          alvo_q, alvo_d;
    logic [IDX_W-1:0]          cnt_q, cnt_d;
    logic                      espera_q, espera_d;
    logic [IDX_W-1:0]          melhor_idx_q, melhor_idx_d;
    logic [CRITERIO_WIDTH-1:0] melhor_crit_q, melhor_crit_d;
    logic [ADR_WIDTH-1:0]      melhor_adr_q, melhor_adr_d;
    logic                      melhor_ok_q, melhor_ok_d;
    logic [ADR_WIDTH-1:0]      resp_adr_q, resp_adr_d;
    logic [CRITERIO_WIDTH-1:0] resp_crit_q, resp_crit_d;
    logic                      resp_vazio_q, resp_vazio_d;

    logic                      acha_ok, livre_ok, alvo_ok;
    logic [IDX_W-1:0]          acha_idx, livre_idx, alvo_idx;
    logic [ADR_WIDTH-1:0]      cand_adr;
    logic [CRITERIO_WIDTH-1:0] cand_crit;
    logic                      cand_melhor;

    // Descending scan so the lowest matching / free slot is the one that sticks.
    always_comb begin
        acha_ok   = 1'b0;
        acha_idx  = '0;
        livre_ok  = 1'b0;
        livre_idx = '0;
        for (int i = N_NOS - 1; i >= 0; i--) begin
            if (na_ativo_in[i] && (na_endereco_in[i*ADR_WIDTH +: ADR_WIDTH] == ins_adr_q)) begin
                acha_ok  = 1'b1;
                acha_idx = IDX_W'(i);
            end
            if (!na_ativo_in[i]) begin
                livre_ok  = 1'b1;
                livre_idx = IDX_W'(i);
            end
        end
        alvo_ok  = acha_ok | livre_ok;
        alvo_idx = acha_ok ? acha_idx : livre_idx;
    end

    assign cand_adr    = na_endereco_in[cnt_q*ADR_WIDTH +: ADR_WIDTH];
    assign cand_crit   = na_criterio_in[cnt_q*CRITERIO_WIDTH +: CRITERIO_WIDTH];
    // Strict less-than keeps the earlier (lower-index) slot on ties.
    assign cand_melhor = na_ativo_in[cnt_q] && (!melhor_ok_q || (cand_crit < melhor_crit_q));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q      <= IDLE;
            ins_adr_q     <= '0;
            ins_dist_q    <= '0;
            ins_ant_q     <= '0;
            alvo_q        <= '0;
            cnt_q         <= '0;
            espera_q      <= 1'b0;
            melhor_idx_q  <= '0;
            melhor_crit_q <= '0;
            melhor_adr_q  <= '0;
            melhor_ok_q   <= 1'b0;
            resp_adr_q    <= '0;
            resp_crit_q   <= '0;
            resp_vazio_q  <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            ins_adr_q     <= ins_adr_d;
            ins_dist_q    <= ins_dist_d;
            ins_ant_q     <= ins_ant_d;
            alvo_q        <= alvo_d;
            cnt_q         <= cnt_d;
            espera_q      <= espera_d;
            melhor_idx_q  <= melhor_idx_d;
            melhor_crit_q <= melhor_crit_d;
            melhor_adr_q  <= melhor_adr_d;
            melhor_ok_q   <= melhor_ok_d;
            resp_adr_q    <= resp_adr_d;
            resp_crit_q   <= resp_crit_d;
            resp_vazio_q  <= resp_vazio_d;
        end
    end

    // NOTE: every signal gets a default hold value first so no path through the
    // case statement leaves it unassigned, which would infer a latch.
    always_comb begin
        estado_d      = estado_q;
        ins_adr_d     = ins_adr_q;
        ins_dist_d    = ins_dist_q;
        ins_ant_d     = ins_ant_q;
        alvo_d        = alvo_q;
        cnt_d         = cnt_q;
        espera_d      = espera_q;
        melhor_idx_d  = melhor_idx_q;
        melhor_crit_d = melhor_crit_q;
        melhor_adr_d  = melhor_adr_q;
        melhor_ok_d   = melhor_ok_q;
        resp_adr_d    = resp_adr_q;
        resp_crit_d   = resp_crit_q;
        resp_vazio_d  = resp_vazio_q;

        unique case (estado_q)
            IDLE: begin
                if (ins_valid_in) begin
                    ins_adr_d  = ins_endereco_in;
                    ins_dist_d = ins_distancia_in;
                    ins_ant_d  = ins_anterior_in;
                    estado_d   = BUSCA;
                end else if (prox_valid_in) begin
                    cnt_d         = '0;
                    melhor_ok_d   = 1'b0;
                    melhor_idx_d  = '0;
                    melhor_crit_d = '0;
                    melhor_adr_d  = '0;
                    estado_d      = SELECAO;
                end
            end
            BUSCA: begin
                if (alvo_ok) begin
                    alvo_d   = alvo_idx;
                    estado_d = ESCRITA;
                end else begin
                    estado_d = IDLE;
                end
            end
            ESCRITA: begin
                espera_d = 1'b0;
                estado_d = ESPERA;
            end
            SELECAO: begin
                if (cand_melhor) begin
                    melhor_ok_d   = 1'b1;
                    melhor_idx_d  = cnt_q;
                    melhor_crit_d = cand_crit;
                    melhor_adr_d  = cand_adr;
                end
                if (cnt_q == ULTIMO) begin
                    estado_d = REMOCAO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REMOCAO: begin
                resp_adr_d   = melhor_ok_q ? melhor_adr_q : '0;
                resp_crit_d  = melhor_ok_q ? melhor_crit_q : '0;
                resp_vazio_d = !melhor_ok_q;
                espera_d     = 1'b0;
                estado_d     = melhor_ok_q ? ESPERA : IDLE;
            end
            ESPERA: begin
                // Two cycles let the slot's criterion/active registers settle.
                if (espera_q) begin
                    estado_d = IDLE;
                end else begin
                    espera_d = 1'b1;
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    always_comb begin
        ready_out         = rst_n && (estado_q == IDLE);
        ga_habilitar_out  = 1'b0;
        atualizar_out     = '0;
        desativar_out     = '0;
        endereco_out      = '0;
        distancia_out     = '0;
        anterior_out      = '0;
        resp_valid_out    = 1'b0;
        resp_endereco_out = resp_adr_q;
        resp_criterio_out = resp_crit_q;
        resp_vazio_out    = resp_vazio_q;
        erro_cheio_out    = 1'b0;

        unique case (estado_q)
            BUSCA: erro_cheio_out = !alvo_ok;
            ESCRITA: begin
                ga_habilitar_out      = 1'b1;
                atualizar_out[alvo_q] = 1'b1;
                endereco_out          = ins_adr_q;
                distancia_out         = ins_dist_q;
                anterior_out          = ins_ant_q;
            end
            REMOCAO: begin
                resp_valid_out    = 1'b1;
                resp_endereco_out = melhor_ok_q ? melhor_adr_q : '0;
                resp_criterio_out = melhor_ok_q ? melhor_crit_q : '0;
                resp_vazio_out    = !melhor_ok_q;
                if (melhor_ok_q) begin
                    ga_habilitar_out            = 1'b1;
                    desativar_out[melhor_idx_q] = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_escalonador_ativos.sv
// Directed bench for escalonador_ativos: insert, update, pool-full, extraction,
// empty extraction and reset in the middle of a scan.
module tb_escalonador_ativos;

    localparam int N  = 8;
    localparam int AW = 5;
    localparam int DW = 5;
    localparam int CW = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ins_valid_in;
    logic [AW-1:0]   ins_endereco_in;
    logic [DW-1:0]   ins_distancia_in;
    logic [AW-1:0]   ins_anterior_in;
    logic            prox_valid_in;
    logic            ready_out;
    logic [N-1:0]    na_ativo_in;
    logic [N*AW-1:0] na_endereco_in;
    logic [N*CW-1:0] na_criterio_in;
    logic            ga_habilitar_out;
    logic [N-1:0]    atualizar_out;
    logic [N-1:0]    desativar_out;
    logic [AW-1:0]   endereco_out;
    logic [DW-1:0]   distancia_out;
    logic [AW-1:0]   anterior_out;
    logic            resp_valid_out;
    logic [AW-1:0]   resp_endereco_out;
    logic [CW-1:0]   resp_criterio_out;
    logic            resp_vazio_out;
    logic            erro_cheio_out;

    int checks = 0;
    int errors = 0;

    escalonador_ativos #(
        .N_NOS(N), .ADR_WIDTH(AW), .DISTANCIA_WIDTH(DW), .CRITERIO_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ins_valid_in(ins_valid_in), .ins_endereco_in(ins_endereco_in),
        .ins_distancia_in(ins_distancia_in), .ins_anterior_in(ins_anterior_in),
        .prox_valid_in(prox_valid_in), .ready_out(ready_out),
        .na_ativo_in(na_ativo_in), .na_endereco_in(na_endereco_in),
        .na_criterio_in(na_criterio_in), .ga_habilitar_out(ga_habilitar_out),
        .atualizar_out(atualizar_out), .desativar_out(desativar_out),
        .endereco_out(endereco_out), .distancia_out(distancia_out),
        .anterior_out(anterior_out), .resp_valid_out(resp_valid_out),
        .resp_endereco_out(resp_endereco_out), .resp_criterio_out(resp_criterio_out),
        .resp_vazio_out(resp_vazio_out), .erro_cheio_out(erro_cheio_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [AW-1:0] adr, input logic [CW-1:0] crit);
        na_endereco_in[i*AW +: AW] = adr;
        na_criterio_in[i*CW +: CW] = crit;
    endtask

    initial begin
        rst_n            = 1'b0;
        ins_valid_in     = 1'b0;
        ins_endereco_in  = '0;
        ins_distancia_in = '0;
        ins_anterior_in  = '0;
        prox_valid_in    = 1'b0;
        na_ativo_in      = '0;
        na_endereco_in   = '0;
        na_criterio_in   = '0;

        // Reset state
        #12;
        check("rst_ready", ready_out, 0);
        check("rst_ga", ga_habilitar_out, 0);
        check("rst_resp_valid", resp_valid_out, 0);
        check("rst_erro", erro_cheio_out, 0);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", ready_out, 1);

        // Insert addr 3 dist 4 into empty pool
        ins_valid_in = 1'b1; ins_endereco_in = 5'd3; ins_distancia_in = 5'd4; ins_anterior_in = 5'd2;
        tick();                                    // T+1 BUSCA
        ins_valid_in = 1'b0; ins_endereco_in = 5'd9; ins_distancia_in = 5'd7;
        check("ins1_busy", ready_out, 0);
        check("ins1_no_erro", erro_cheio_out, 0);
        tick();                                    // T+2 ESCRITA
        check("ins1_ga", ga_habilitar_out, 1);
        check("ins1_atualizar", atualizar_out, 8'h01);
        check("ins1_desativar", desativar_out, 0);
        check("ins1_endereco", endereco_out, 3);
        check("ins1_distancia", distancia_out, 4);
        check("ins1_anterior", anterior_out, 2);
        tick();                                    // T+3
        check("ins1_strobe_off", atualizar_out, 0);
        check("ins1_t3_ready", ready_out, 0);
        tick();                                    // T+4
        check("ins1_t4_ready", ready_out, 0);
        tick();                                    // T+5
        check("ins1_t5_ready", ready_out, 1);

        // Re-insert addr 3 while slot 0 holds it
        na_ativo_in = 8'h01; set_slot(0, 5'd3, 5'd4);
        ins_valid_in = 1'b1; ins_endereco_in = 5'd3; ins_distancia_in = 5'd2; ins_anterior_in = 5'd1;
        tick();
        ins_valid_in = 1'b0;
        tick();
        check("upd_atualizar", atualizar_out, 8'h01);
        check("upd_distancia", distancia_out, 2);
        tick(); tick(); tick();

        // Match in slot 2 wins over free slot 1
        na_ativo_in = 8'h05; set_slot(0, 5'd7, 5'd1); set_slot(2, 5'd3, 5'd1);
        ins_valid_in = 1'b1; ins_endereco_in = 5'd3; ins_distancia_in = 5'd6;
        tick();
        ins_valid_in = 1'b0;
        tick();
        check("match_atualizar", atualizar_out, 8'h04);
        tick(); tick(); tick();

        // Full pool, new address
        na_ativo_in = 8'hFF;
        for (int i = 0; i < N; i++) set_slot(i, AW'(i + 10), 5'd1);
        ins_valid_in = 1'b1; ins_endereco_in = 5'd20;
        tick();                                    // BUSCA
        ins_valid_in = 1'b0;
        check("full_erro", erro_cheio_out, 1);
        check("full_atualizar", atualizar_out, 0);
        tick();
        check("full_erro_pulse", erro_cheio_out, 0);
        check("full_ready", ready_out, 1);
        check("full_no_write", ga_habilitar_out, 0);

        // Extraction: slots 1,4,6 active with criteria 9,5,5
        na_ativo_in = 8'h52;
        set_slot(1, 5'd11, 5'd9); set_slot(4, 5'd14, 5'd5); set_slot(6, 5'd16, 5'd5);
        prox_valid_in = 1'b1;
        tick();                                    // T+1 first SELECAO cycle
        prox_valid_in = 1'b0;
        for (int k = 0; k < N; k++) begin
            check("sel_no_strobe", desativar_out, 0);
            tick();
        end                                        // T+N+1 REMOCAO
        check("rem_resp_valid", resp_valid_out, 1);
        check("rem_desativar", desativar_out, 8'h10);
        check("rem_ga", ga_habilitar_out, 1);
        check("rem_atualizar", atualizar_out, 0);
        check("rem_endereco", resp_endereco_out, 14);
        check("rem_criterio", resp_criterio_out, 5);
        check("rem_vazio", resp_vazio_out, 0);
        tick();
        check("rem_valid_pulse", resp_valid_out, 0);
        check("rem_desativar_off", desativar_out, 0);
        check("rem_held_endereco", resp_endereco_out, 14);
        check("rem_espera_ready", ready_out, 0);
        tick(); tick();
        check("rem_ready", ready_out, 1);

        // Insert has priority over extraction
        ins_valid_in = 1'b1; prox_valid_in = 1'b1; ins_endereco_in = 5'd20; ins_distancia_in = 5'd3;
        tick();
        ins_valid_in = 1'b0; prox_valid_in = 1'b0;
        tick();
        check("prio_atualizar", atualizar_out, 8'h01);
        check("prio_desativar", desativar_out, 0);
        tick(); tick(); tick();

        // Extraction on empty pool
        na_ativo_in = 8'h00;
        prox_valid_in = 1'b1;
        tick();
        prox_valid_in = 1'b0;
        for (int k = 0; k < N; k++) tick();
        check("vazio_valid", resp_valid_out, 1);
        check("vazio_flag", resp_vazio_out, 1);
        check("vazio_endereco", resp_endereco_out, 0);
        check("vazio_criterio", resp_criterio_out, 0);
        check("vazio_desativar", desativar_out, 0);
        check("vazio_ga", ga_habilitar_out, 0);
        tick();
        check("vazio_ready", ready_out, 1);
        check("vazio_held", resp_vazio_out, 1);

        // Reset in the middle of SELECAO
        na_ativo_in = 8'h52;
        prox_valid_in = 1'b1;
        tick();
        prox_valid_in = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("midrst_ready", ready_out, 0);
        check("midrst_desativar", desativar_out, 0);
        check("midrst_atualizar", atualizar_out, 0);
        check("midrst_vazio", resp_vazio_out, 0);
        #5;
        rst_n = 1'b1;
        tick();
        check("midrst_idle", ready_out, 1);
        prox_valid_in = 1'b1;
        tick();
        prox_valid_in = 1'b0;
        for (int k = 0; k < N; k++) tick();
        check("after_rst_desativar", desativar_out, 8'h10);
        check("after_rst_endereco", resp_endereco_out, 14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
